// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - ALU control codes understood by the downstream alu datapath
//   - RV32I opcodes recognised by the decoder
//   - issue_entry_t: one decoded instruction as held in the issue queue
//   - queue_state_t: occupancy of the two-entry head/skid queue
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SSUB = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  control;
        logic [4:0]  rd;
        logic        wr_en;
        logic        is_branch;
        logic [2:0]  funct3;
        logic        illegal;
    } issue_entry_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } queue_state_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational RV32I decode into an issue entry.
// Ports:
//   instr     in  32  raw instruction word
//   pc        in  32  address of instr
//   rs1_data  in  32  register-file read data for instr[19:15]
//   rs2_data  in  32  register-file read data for instr[24:20]
//   entry     out     decoded issue_entry_t
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    input  logic [31:0]  rs1_data,
    input  logic [31:0]  rs2_data,
    output issue_entry_t entry
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'b0};
    assign shamt    = {27'b0, instr[24:20]};

    logic        legal;
    logic        writes;
    logic        branch;
    logic [3:0]  ctl;
    logic [31:0] op1;
    logic [31:0] op2;

    always_comb begin
        legal  = 1'b1;
        writes = 1'b0;
        branch = 1'b0;
        ctl    = ALU_ADD;
        op1    = '0;
        op2    = '0;
        case (opcode)
            OPC_OP: begin
                op1    = rs1_data;
                op2    = rs2_data;
                writes = 1'b1;
                if (f7 == 7'h00)
                    ctl = {1'b0, f3};
                else if (f7 == 7'h20 && f3 == 3'b000)
                    ctl = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'b101)
                    ctl = ALU_SRA;
                else
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                op1    = rs1_data;
                op2    = imm_i;
                writes = 1'b1;
                case (f3)
                    3'b001: begin
                        op2 = shamt;
                        if (f7 == 7'h00) ctl = ALU_SLL;
                        else             legal = 1'b0;
                    end
                    3'b101: begin
                        op2 = shamt;
                        if (f7 == 7'h00)      ctl = ALU_SRL;
                        else if (f7 == 7'h20) ctl = ALU_SRA;
                        else                  legal = 1'b0;
                    end
                    default: ctl = {1'b0, f3};
                endcase
            end
            OPC_LUI: begin
                op2    = imm_u;
                writes = 1'b1;
            end
            OPC_AUIPC: begin
                op1    = pc;
                op2    = imm_u;
                writes = 1'b1;
            end
            OPC_BRANCH: begin
                op1    = rs1_data;
                op2    = rs2_data;
                branch = 1'b1;
                case (f3)
                    3'b000, 3'b001: ctl = ALU_SUB;
                    3'b100, 3'b101: ctl = ALU_SLT;
                    3'b110, 3'b111: ctl = ALU_SLTU;
                    default:        legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // An illegal entry still travels down the pipe, but carries nothing
    // the execute stage could act on except the flag itself.
    always_comb begin
        entry           = '0;
        entry.funct3    = f3;
        entry.illegal   = ~legal;
        entry.in1       = legal ? op1 : 32'b0;
        entry.in2       = legal ? op2 : 32'b0;
        entry.control   = legal ? ctl : ALU_ADD;
        entry.is_branch = legal & branch;
        entry.wr_en     = legal & writes & (rd_field != 5'd0);
        entry.rd        = entry.wr_en ? rd_field : 5'd0;
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: registered issue stage in front of the alu datapath.
// Decodes one instruction per cycle and holds it in a two-entry
// head/skid queue so out_ready never reaches in_ready combinationally.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake
//   instr, pc              instruction word and its address
//   rs1_data, rs2_data     register-file operands
//   out_valid / out_ready  execute-stage handshake
//   alu_in1, alu_in2       operand pair of the head entry
//   alu_control            ALU operation code of the head entry
//   rd, wr_en              writeback tag of the head entry
//   is_branch, funct3      branch marker and condition for the resolver
//   illegal                head entry was not a supported instruction
//
// state   | meaning
// --------+----------------------------------------------
// Q_EMPTY | no entry, out_valid low
// Q_ONE   | head valid, skid free
// Q_FULL  | head and skid valid, in_ready low
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_control,
    output logic [4:0]  rd,
    output logic        wr_en,
    output logic        is_branch,
    output logic [2:0]  funct3,
    output logic        illegal
);

    issue_entry_t decoded;
    issue_entry_t head;
    issue_entry_t skid;
    queue_state_t state;
    queue_state_t state_next;

    logic push;
    logic pop;
    logic load_head;
    logic load_skid;
    logic skid_to_head;

    alu_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .entry    (decoded)
    );

    assign in_ready  = ~reset & (state != Q_FULL);
    assign out_valid = (state != Q_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_next   = state;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        case (state)
            Q_EMPTY: begin
                if (push) begin
                    state_next = Q_ONE;
                    load_head  = 1'b1;
                end
            end
            Q_ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_next = Q_FULL;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = Q_EMPTY;
                end
            end
            Q_FULL: begin
                if (pop) begin
                    state_next   = Q_ONE;
                    skid_to_head = 1'b1;
                end
            end
            default: state_next = Q_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= Q_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_next;
            if (load_head)
                head <= decoded;
            else if (skid_to_head)
                head <= skid;
            if (load_skid)
                skid <= decoded;
        end
    end

    assign alu_in1     = head.in1;
    assign alu_in2     = head.in2;
    assign alu_control = head.control;
    assign rd          = head.rd;
    assign wr_en       = head.wr_en;
    assign is_branch   = head.is_branch;
    assign funct3      = head.funct3;
    assign illegal     = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: decode vector table streamed
// back-to-back, then backpressure and reset-while-full sequences.
module tb_alu_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic        wr_en;
    logic        is_branch;
    logic [2:0]  funct3;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .rd          (rd),
        .wr_en       (wr_en),
        .is_branch   (is_branch),
        .funct3      (funct3),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] e_in1;
        logic [31:0] e_in2;
        logic [3:0]  e_ctl;
        logic [4:0]  e_rd;
        logic        e_wr;
        logic        e_br;
        logic [2:0]  e_f3;
        logic        e_ill;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input vec_t v);
        check({tag, ".out_valid"},   {31'b0, out_valid},  32'd1);
        check({tag, ".alu_in1"},     alu_in1,             v.e_in1);
        check({tag, ".alu_in2"},     alu_in2,             v.e_in2);
        check({tag, ".alu_control"}, {28'b0, alu_control}, {28'b0, v.e_ctl});
        check({tag, ".rd"},          {27'b0, rd},         {27'b0, v.e_rd});
        check({tag, ".wr_en"},       {31'b0, wr_en},      {31'b0, v.e_wr});
        check({tag, ".is_branch"},   {31'b0, is_branch},  {31'b0, v.e_br});
        check({tag, ".funct3"},      {29'b0, funct3},     {29'b0, v.e_f3});
        check({tag, ".illegal"},     {31'b0, illegal},    {31'b0, v.e_ill});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"},   {31'b0, out_valid},  32'd0);
        check({tag, ".alu_in1"},     alu_in1,             32'd0);
        check({tag, ".alu_in2"},     alu_in2,             32'd0);
        check({tag, ".alu_control"}, {28'b0, alu_control}, 32'd0);
        check({tag, ".rd"},          {27'b0, rd},         32'd0);
        check({tag, ".wr_en"},       {31'b0, wr_en},      32'd0);
        check({tag, ".is_branch"},   {31'b0, is_branch},  32'd0);
        check({tag, ".funct3"},      {29'b0, funct3},     32'd0);
        check({tag, ".illegal"},     {31'b0, illegal},    32'd0);
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        instr    = v.instr;
        pc       = v.pc;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          name         instr         pc        rs1           rs2      in1           in2           ctl    rd  wr br f3  ill
        vecs[0]  = '{"add",      32'h002081B3, 32'h0,   32'd5,        32'd7,   32'd5,        32'd7,        4'h0, 5'd3, 1, 0, 3'd0, 0};
        vecs[1]  = '{"srai",     32'h40335293, 32'h0,   32'h80000000, 32'd9,   32'h80000000, 32'd3,        4'hD, 5'd5, 1, 0, 3'd5, 0};
        vecs[2]  = '{"addi_m1",  32'hFFF00093, 32'h0,   32'd0,        32'd4,   32'd0,        32'hFFFFFFFF, 4'h0, 5'd1, 1, 0, 3'd0, 0};
        vecs[3]  = '{"lui",      32'h12345137, 32'h40,  32'h0000DEAD, 32'd1,   32'd0,        32'h12345000, 4'h0, 5'd2, 1, 0, 3'd5, 0};
        vecs[4]  = '{"auipc",    32'h00001097, 32'h100, 32'h55,       32'h66,  32'h100,      32'h1000,     4'h0, 5'd1, 1, 0, 3'd1, 0};
        vecs[5]  = '{"blt",      32'h0020C063, 32'h0,   32'd3,        32'd9,   32'd3,        32'd9,        4'h2, 5'd0, 0, 1, 3'd4, 0};
        vecs[6]  = '{"opc_7f",   32'h0000007F, 32'h0,   32'd1,        32'd2,   32'd0,        32'd0,        4'h0, 5'd0, 0, 0, 3'd0, 1};
        vecs[7]  = '{"sub",      32'h40208233, 32'h0,   32'd10,       32'd3,   32'd10,       32'd3,        4'h8, 5'd4, 1, 0, 3'd0, 0};
        vecs[8]  = '{"op_f7_bad",32'h40209233, 32'h0,   32'd10,       32'd3,   32'd0,        32'd0,        4'h0, 5'd0, 0, 0, 3'd1, 1};
        vecs[9]  = '{"slli",     32'h00509393, 32'h0,   32'h11,       32'h99,  32'h11,       32'd5,        4'h1, 5'd7, 1, 0, 3'd1, 0};
        vecs[10] = '{"bgeu",     32'h0020F063, 32'h0,   32'd1,        32'd2,   32'd1,        32'd2,        4'h3, 5'd0, 0, 1, 3'd7, 0};
        vecs[11] = '{"br_f3_010",32'h0020A063, 32'h0,   32'd1,        32'd2,   32'd0,        32'd0,        4'h0, 5'd0, 0, 0, 3'd2, 1};
        vecs[12] = '{"add_x0",   32'h00208033, 32'h0,   32'd8,        32'd9,   32'd8,        32'd9,        4'h0, 5'd0, 0, 0, 3'd0, 0};
        vecs[13] = '{"sltu",     32'h0020B2B3, 32'h0,   32'd4,        32'd6,   32'd4,        32'd6,        4'h3, 5'd5, 1, 0, 3'd3, 0};
        vecs[14] = '{"xori_neg", 32'h8000C093, 32'h0,   32'h0F0F,     32'd0,   32'h0F0F,     32'hFFFFF800, 4'h4, 5'd1, 1, 0, 3'd4, 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;

        step();
        step();
        check_all_zero("reset");
        check("reset.in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_reset.in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back stream with out_ready high: each entry is visible the
        // cycle after its push, while the next one is already being pushed.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            check($sformatf("%s.in_ready", vecs[i].name), {31'b0, in_ready}, 32'd1);
            step();
            check_head(vecs[i].name, vecs[i]);
        end
        in_valid = 1'b0;
        step();
        check("drain.out_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: three pushes with out_ready low, only two fit.
        out_ready = 1'b0;
        drive(vecs[0]);
        check("bp.push1.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        drive(vecs[2]);
        check("bp.push2.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        drive(vecs[3]);
        check("bp.push3.in_ready", {31'b0, in_ready}, 32'd0);
        check_head("bp.stall0", vecs[0]);
        step();
        check("bp.stall1.in_ready", {31'b0, in_ready}, 32'd0);
        check_head("bp.stall1", vecs[0]);
        step();
        check_head("bp.stall2", vecs[0]);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_head("bp.pop1", vecs[2]);
        check("bp.pop1.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("bp.pop2.out_valid", {31'b0, out_valid}, 32'd0);

        // Reset while full discards both entries and the input in that cycle.
        out_ready = 1'b0;
        drive(vecs[5]);
        step();
        drive(vecs[7]);
        step();
        check("rst.full.in_ready", {31'b0, in_ready}, 32'd0);
        check_head("rst.full", vecs[5]);
        drive(vecs[9]);
        reset = 1'b1;
        #1;
        check("rst.asserted.in_ready", {31'b0, in_ready}, 32'd0);
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("rst.after");
        check("rst.after.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("rst.idle.out_valid", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
